unpacking_and_extracting: RTL and testbench
===========================================

// Module: unpacking_and_extracting
// PURPOSE
//   Decompression-side counterpart of the stage-3 packer. Accepts the packed stream as
//   CACHE_LINE-bit chunks and buffers them in a bit FIFO. Parses one variable-length token
//   (3-bit code + index/literal payload) per cycle and presents it to the dictionary-lookup
//   stage over a valid/ready handshake. Counts tokens per line and re-aligns to the next chunk.
// PARAMETERS
//   CACHE_LINE     64   packed input chunk width (bits)
//   WORD_WIDTH     32   uncompressed word width
//   DICT_WORD      16   dictionary entries; index width IDX_W = $clog2(DICT_WORD) = 4
//   BUF_WIDTH      128  bit-buffer width; must be >= CACHE_LINE + 35 - 1
//   WORDS_PER_LINE 16   tokens per compressed line
// PORTS
//   i_clk        in   1           clock, rising edge
//   i_rst_n      in   1           asynchronous active-low reset
//   i_in_valid   in   1           i_in_data valid
//   o_in_ready   out  1           buffer can accept a chunk this cycle
//   i_in_data    in   CACHE_LINE  packed chunk; bit CACHE_LINE-1 is the oldest bit
//   i_in_last    in   1           chunk is the final chunk of the current line
//   o_tok_valid  out  1           decoded token valid
//   i_tok_ready  in   1           downstream accepts token
//   o_code       out  3           token code
//   o_idx        out  IDX_W       dictionary index (0 if code carries none)
//   o_payload    out  WORD_WIDTH  literal bits, right-aligned, zero-extended
//   o_tok_last   out  1           token is the WORDS_PER_LINE-th of the line
//   o_error      out  1           sticky: illegal code or line underflow
// BEHAVIOUR
//   Code table (MSB-first: code, then idx, then literal). Length = total bits:
//     000 ZZZZ 3 | 001 XXXX 3+32=35 | 010 MMMM 3+4=7 | 011 MMXX 3+4+16=23
//     100 ZZZX 3+8=11 | 101 MMMX 3+4+8=15 | 110/111 illegal
//   Buffer: valid bits left-aligned at buf[BUF_WIDTH-1]; fill counter 0..BUF_WIDTH.
//   o_in_ready = (state==FILL) && (fill_after_consume <= BUF_WIDTH-CACHE_LINE) && !o_error.
//   Token available when fill>=3 and fill>=len(code at buf top). Token registered when
//     available && (!o_tok_valid || i_tok_ready); the same edge shifts the buffer left by len.
//   Simultaneous consume+append: chunk is written at position fill-len (post-shift);
//     new fill = fill - len + CACHE_LINE. No bit loss or duplication.
//   Latency: chunk accepted at edge k -> token first valid after edge k+1.
//   Output regs hold stable while o_tok_valid && !i_tok_ready.
//   Token counter 0..WORDS_PER_LINE-1; o_tok_last=1 on the final token. When that token
//     is registered: counter->0, fill->0 (padding dropped), state->FILL.
//   FSM: FILL (accept chunks + decode) -> DRAIN on accepted chunk with i_in_last
//     (no chunks accepted, decode only) -> FILL after last token registered.
//     Any state -> ERR on illegal code at buf top (fill>=3), or in DRAIN with
//     fill < required length. ERR: o_error=1, o_tok_valid=0 once current token
//     taken, o_in_ready=0; exit only via reset.
//   Reset (async, any time incl. mid-line): fill=0, counter=0, state=FILL; all outputs 0
//     (o_in_ready rises the first cycle after release).
// TESTING
//   1 One chunk {16x ZZZZ, 16 pad zeros}, in_last=1 -> 16 tokens code=000, payload=0;
//     tok_last only on the 16th; then fill=0, in_ready=1.
//   2 XXXX 0xDEADBEEF then XXXX 0x12345678 (2nd straddles chunks 1/2), rest MMMM idx=5
//     -> payloads exact; 3rd token code=010, idx=5.
//   3 Mixed MMXX idx=3 low=0xBEEF, ZZZX 0xA5, MMMX idx=7 0x5A -> fields exact, correct order.
//   4 i_tok_ready low 6 cycles while chunks stream -> outputs frozen; in_ready drops
//     once fill > 64; no bits lost when ready returns (compare against model).
//   5 Code 110 at token 4 -> o_error=1 next edge, no further tokens, in_ready=0 until reset.
//     Also in_last with 5 bits left needing 7 (MMMM) -> o_error=1.
//   6 Assert i_rst_n low mid-line (fill=40) -> outputs 0 immediately; new line after
//     release decodes from its first bit.

Source files
------------

// File: rtl/unpacking_and_extracting.sv
// rtl/unpacking_and_extracting.sv - bit-FIFO unpacker that parses variable-length dictionary tokens
module unpacking_and_extracting #(
  parameter int CACHE_LINE     = 64,
  parameter int WORD_WIDTH     = 32,
  parameter int DICT_WORD      = 16,
  parameter int BUF_WIDTH      = 128,
  parameter int WORDS_PER_LINE = 16,
  localparam int IDX_W         = $clog2(DICT_WORD)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [CACHE_LINE-1:0] i_in_data,
  input  logic                  i_in_last,
  output logic                  o_tok_valid,
  input  logic                  i_tok_ready,
  output logic [2:0]            o_code,
  output logic [IDX_W-1:0]      o_idx,
  output logic [WORD_WIDTH-1:0] o_payload,
  output logic                  o_tok_last,
  output logic                  o_error
);

  localparam int FILL_W = $clog2(BUF_WIDTH + 1);
  localparam int CNT_W  = $clog2(WORDS_PER_LINE);
  localparam int TOP    = BUF_WIDTH - 4;  // first bit after the 3-bit code

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  logic [BUF_WIDTH-1:0]  buf_q;
  logic [FILL_W-1:0]     fill_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [1:0]            state_q;
  logic                  rdy_en_q;

  logic [2:0]            code;
  logic                  legal;
  logic [FILL_W-1:0]     len;
  logic [IDX_W-1:0]      dec_idx;
  logic [WORD_WIDTH-1:0] dec_pay;
  logic                  has_code;
  logic                  avail;
  logic                  take;
  logic [FILL_W-1:0]     take_len;
  logic [FILL_W-1:0]     fill_consumed;
  logic                  last_tok;
  logic                  err_det;
  logic                  accept;
  logic [BUF_WIDTH-1:0]  chunk_pos;
  logic [BUF_WIDTH-1:0]  buf_shift;

  // Decode the token sitting at the top of the bit buffer
  always_comb begin
    code    = buf_q[BUF_WIDTH-1 -: 3];
    legal   = 1'b1;
    len     = '0;
    dec_idx = '0;
    dec_pay = '0;
    case (code)
      3'b000: len = FILL_W'(3);
      3'b001: begin
        len     = FILL_W'(3 + WORD_WIDTH);
        dec_pay = buf_q[TOP -: WORD_WIDTH];
      end
      3'b010: begin
        len     = FILL_W'(3 + IDX_W);
        dec_idx = buf_q[TOP -: IDX_W];
      end
      3'b011: begin
        len     = FILL_W'(3 + IDX_W + 16);
        dec_idx = buf_q[TOP -: IDX_W];
        dec_pay = {{(WORD_WIDTH-16){1'b0}}, buf_q[TOP-IDX_W -: 16]};
      end
      3'b100: begin
        len     = FILL_W'(3 + 8);
        dec_pay = {{(WORD_WIDTH-8){1'b0}}, buf_q[TOP -: 8]};
      end
      3'b101: begin
        len     = FILL_W'(3 + IDX_W + 8);
        dec_idx = buf_q[TOP -: IDX_W];
        dec_pay = {{(WORD_WIDTH-8){1'b0}}, buf_q[TOP-IDX_W -: 8]};
      end
      default: legal = 1'b0;
    endcase
  end

  // Handshake, consume/append arithmetic and error detection
  always_comb begin
    has_code      = fill_q >= FILL_W'(3);
    avail         = has_code && legal && (fill_q >= len) && (state_q != ST_ERR);
    take          = avail && (!o_tok_valid || i_tok_ready);
    take_len      = take ? len : '0;
    fill_consumed = fill_q - take_len;
    last_tok      = cnt_q == CNT_W'(WORDS_PER_LINE - 1);
    // In DRAIN no more bits will arrive, so a short buffer is a truncated line
    err_det       = (state_q != ST_ERR) &&
                    ((has_code && !legal) ||
                     ((state_q == ST_DRAIN) && (!has_code || (legal && fill_q < len))));
    o_in_ready    = rdy_en_q && (state_q == ST_FILL) && !o_error &&
                    (fill_consumed <= FILL_W'(BUF_WIDTH - CACHE_LINE));
    accept        = i_in_valid && o_in_ready;
    // New chunk lands directly behind the bits that survive this cycle's consume
    chunk_pos     = {i_in_data, {(BUF_WIDTH-CACHE_LINE){1'b0}}} >> fill_consumed;
    buf_shift     = buf_q << take_len;
  end

  // Bit buffer, fill level, per-line token counter and line FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q    <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      state_q  <= ST_FILL;
      rdy_en_q <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (take && last_tok) begin
        // Line complete: drop padding; a chunk accepted now starts the next line
        cnt_q <= '0;
        if (accept) begin
          buf_q   <= {i_in_data, {(BUF_WIDTH-CACHE_LINE){1'b0}}};
          fill_q  <= FILL_W'(CACHE_LINE);
          state_q <= i_in_last ? ST_DRAIN : ST_FILL;
        end else begin
          buf_q   <= '0;
          fill_q  <= '0;
          state_q <= ST_FILL;
        end
      end else begin
        if (take) cnt_q <= cnt_q + CNT_W'(1);
        buf_q  <= buf_shift | (accept ? chunk_pos : '0);
        fill_q <= fill_consumed + (accept ? FILL_W'(CACHE_LINE) : '0);
        if (err_det) state_q <= ST_ERR;
        else if (accept && i_in_last) state_q <= ST_DRAIN;
      end
      if (err_det) o_error <= 1'b1;
    end
  end

  // Token output register; holds while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tok_valid <= 1'b0;
      o_code      <= '0;
      o_idx       <= '0;
      o_payload   <= '0;
      o_tok_last  <= 1'b0;
    end else if (take) begin
      o_tok_valid <= 1'b1;
      o_code      <= code;
      o_idx       <= dec_idx;
      o_payload   <= dec_pay;
      o_tok_last  <= last_tok;
    end else if (i_tok_ready) begin
      o_tok_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_unpacking_and_extracting.sv
// tb/tb_unpacking_and_extracting.sv - directed self-checking bench for unpacking_and_extracting
module tb_unpacking_and_extracting;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        tok_valid;
  logic        tok_ready = 1'b1;
  logic [2:0]  code;
  logic [3:0]  idx;
  logic [31:0] payload;
  logic        tok_last;
  logic        error;

  unpacking_and_extracting dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data), .i_in_last(in_last),
    .o_tok_valid(tok_valid), .i_tok_ready(tok_ready),
    .o_code(code), .o_idx(idx), .o_payload(payload), .o_tok_last(tok_last), .o_error(error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1023:0] sb;
  int            sp, ntok, nch;
  logic [2:0]    e_code [32];
  logic [3:0]    e_idx  [32];
  logic [31:0]   e_pay  [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stream();
    sb = '0; sp = 0; ntok = 0;
  endtask

  task automatic put(input int n, input logic [34:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      sb[1023 - sp] = v[i];
      sp++;
    end
  endtask

  task automatic add_tok(input logic [2:0] c, input logic [3:0] ix, input logic [31:0] lit);
    logic [31:0] p;
    logic [3:0]  x;
    p = '0; x = '0;
    put(3, {32'd0, c});
    case (c)
      3'b001: begin put(32, {3'd0, lit}); p = lit; end
      3'b010: begin put(4, {31'd0, ix}); x = ix; end
      3'b011: begin put(4, {31'd0, ix}); put(16, {19'd0, lit[15:0]}); x = ix; p = {16'd0, lit[15:0]}; end
      3'b100: begin put(8, {27'd0, lit[7:0]}); p = {24'd0, lit[7:0]}; end
      3'b101: begin put(4, {31'd0, ix}); put(8, {27'd0, lit[7:0]}); x = ix; p = {24'd0, lit[7:0]}; end
      default: ;
    endcase
    e_code[ntok] = c; e_idx[ntok] = x; e_pay[ntok] = p;
    ntok++;
  endtask

  // Streams the built chunks and checks every handshaken token against the expected list.
  task automatic run_line(input string tag, input bit last_flag, input int stall_from,
                          input int stall_len, input bit expect_err, input int budget);
    int ci, ti, last_cyc;
    logic [31:0] s_pay;
    logic [2:0]  s_code;
    logic        s_valid;
    ci = 0; ti = 0; last_cyc = -10;
    s_pay = '0; s_code = '0; s_valid = 1'b0;
    nch = (sp + 63) / 64;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (!expect_err && ti >= ntok) break;
      @(negedge clk);
      tok_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (ci < nch) begin
        in_valid = 1'b1;
        in_data  = sb[1023 - 64*ci -: 64];
        in_last  = last_flag && (ci == nch - 1);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      #1;
      if (cyc == stall_from) begin
        s_pay = payload; s_code = code; s_valid = tok_valid;
      end
      if (cyc > stall_from && cyc <= stall_from + stall_len) begin
        check($sformatf("%s_frozen_valid", tag), {31'd0, tok_valid}, {31'd0, s_valid});
        check($sformatf("%s_frozen_code", tag), {29'd0, code}, {29'd0, s_code});
        check($sformatf("%s_frozen_payload", tag), payload, s_pay);
      end
      if (stall_len > 0 && cyc == stall_from + stall_len - 1)
        check($sformatf("%s_stall_in_ready", tag), {31'd0, in_ready}, 32'd0);
      if (expect_err && cyc == last_cyc + 1)
        check($sformatf("%s_error_rise", tag), {31'd0, error}, 32'd1);
      if (tok_valid && tok_ready) begin
        if (ti >= ntok) begin
          check($sformatf("%s_extra_token", tag), 32'd1, 32'd0);
        end else begin
          check($sformatf("%s_code%0d", tag, ti), {29'd0, code}, {29'd0, e_code[ti]});
          check($sformatf("%s_idx%0d", tag, ti), {28'd0, idx}, {28'd0, e_idx[ti]});
          check($sformatf("%s_payload%0d", tag, ti), payload, e_pay[ti]);
          check($sformatf("%s_last%0d", tag, ti), {31'd0, tok_last},
                {31'd0, (!expect_err && ti == 15)});
          check($sformatf("%s_error_low%0d", tag, ti), {31'd0, error}, 32'd0);
          if (ti == ntok - 1) last_cyc = cyc;
        end
        ti++;
      end
      if (in_valid && in_ready) ci++;
    end
    check($sformatf("%s_token_count", tag), ti, ntok);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; tok_ready = 1'b1;
    #1;
    if (expect_err) begin
      check($sformatf("%s_error_sticky", tag), {31'd0, error}, 32'd1);
      check($sformatf("%s_err_tok_valid", tag), {31'd0, tok_valid}, 32'd0);
      in_valid = 1'b1; in_data = 64'hFFFF_0000_FFFF_0000;
      #1;
      check($sformatf("%s_err_in_ready", tag), {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
    end else begin
      check($sformatf("%s_end_tok_valid", tag), {31'd0, tok_valid}, 32'd0);
      check($sformatf("%s_end_in_ready", tag), {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("rst_after_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_tok_valid", {31'd0, tok_valid}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_payload", payload, 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("first_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: sixteen ZZZZ tokens plus padding in a single final chunk
    clear_stream();
    for (int i = 0; i < 16; i++) add_tok(3'b000, 4'd0, 32'd0);
    run_line("t1", 1'b1, 1000, 0, 1'b0, 100);

    // 2: two full literals, the second straddling chunks, then MMMM idx 5
    clear_stream();
    add_tok(3'b001, 4'd0, 32'hDEADBEEF);
    add_tok(3'b001, 4'd0, 32'h12345678);
    for (int i = 0; i < 14; i++) add_tok(3'b010, 4'd5, 32'd0);
    run_line("t2", 1'b1, 1000, 0, 1'b0, 100);

    // 3: mixed partial matches and partial literals
    clear_stream();
    add_tok(3'b011, 4'd3, 32'h0000BEEF);
    add_tok(3'b100, 4'd0, 32'h000000A5);
    add_tok(3'b101, 4'd7, 32'h0000005A);
    for (int i = 0; i < 13; i++) add_tok((i % 2 == 0) ? 3'b000 : 3'b010, 4'(i), 32'd0);
    run_line("t3", 1'b1, 1000, 0, 1'b0, 100);

    // 4: downstream stall for 6 cycles while nine chunks stream in
    clear_stream();
    for (int i = 0; i < 16; i++) add_tok(3'b001, 4'd0, 32'hC0DE0000 + i * 32'h01010001);
    run_line("t4", 1'b1, 4, 6, 1'b0, 200);

    // 5a: illegal code after four tokens
    clear_stream();
    for (int i = 0; i < 4; i++) add_tok(3'b000, 4'd0, 32'd0);
    put(3, 35'b110);
    run_line("t5a", 1'b0, 1000, 0, 1'b1, 20);
    do_reset();

    // 5b: final chunk ends with 5 bits of an MMMM that needs 7
    clear_stream();
    add_tok(3'b001, 4'd0, 32'h0BADF00D);
    add_tok(3'b010, 4'd1, 32'd0);
    add_tok(3'b010, 4'd2, 32'd0);
    add_tok(3'b010, 4'd3, 32'd0);
    add_tok(3'b000, 4'd0, 32'd0);
    put(5, 35'b01000);
    run_line("t5b", 1'b1, 1000, 0, 1'b1, 20);
    do_reset();

    // 6: asynchronous reset mid-line with 40 bits buffered
    clear_stream();
    for (int i = 0; i < 16; i++) add_tok(3'b000, 4'd0, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_data = sb[1023 -: 64]; in_last = 1'b0; tok_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_tok_valid", {31'd0, tok_valid}, 32'd0);
    check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("t6_rst_code", {29'd0, code}, 32'd0);
    check("t6_rst_error", {31'd0, error}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_release_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("t6_after_in_ready", {31'd0, in_ready}, 32'd1);
    clear_stream();
    add_tok(3'b011, 4'd9, 32'h0000CAFE);
    add_tok(3'b101, 4'd2, 32'h00000033);
    for (int i = 0; i < 14; i++) add_tok(3'b100, 4'd0, 32'(i + 16));
    run_line("t6", 1'b1, 1000, 0, 1'b0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
